// File: rtl/qr_result_serializer.sv
// Buffers 480-bit QR results ({R, y_hat}) in a small FIFO and streams each one
// out as twelve 40-bit words with sop/eop framing, frame-done and overflow status.
module qr_result_serializer #(
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_rd_vld,
    input  logic         i_last_data,
    input  logic [159:0] i_y_hat,
    input  logic [319:0] i_r,
    output logic [39:0]  o_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_sop,
    output logic         o_eop,
    output logic         o_frame_done,
    output logic [3:0]   o_res_cnt,
    output logic         o_ovf
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       r_state, w_state_nxt;
    logic [479:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_tag;
    logic [AW:0]  r_wr_ptr, r_rd_ptr;
    logic [3:0]   r_idx, w_idx_nxt;
    logic [39:0]  r_data;
    logic         r_valid, r_sop, r_eop, r_frame_done, r_ovf;
    logic [3:0]   r_res_cnt;

    logic         w_empty, w_full, w_accept, w_pop, w_push, w_avail;
    logic         w_tag_recent, w_pop_last, w_frame_end_empty;
    logic [AW:0]  w_rd_nxt, w_wr_nxt, w_wr_prev;
    logic [479:0] w_src;
    logic [8:0]   w_base;
    logic [39:0]  w_word;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_accept = (r_state == ST_SEND) && r_valid && i_ready;
    assign w_pop    = w_accept && (r_idx == 4'd11);
    // A full FIFO still takes a new result when the head leaves on the same edge.
    assign w_push   = i_rd_vld && (!w_full || w_pop);
    assign w_rd_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};
    assign w_wr_nxt = r_wr_ptr + {{AW{1'b0}}, w_push};
    assign w_wr_prev = r_wr_ptr - {{AW{1'b0}}, 1'b1};
    assign w_avail  = (w_rd_nxt != w_wr_nxt);

    assign w_tag_recent      = i_last_data && !w_push && !w_empty;
    assign w_pop_last        = r_tag[r_rd_ptr[AW-1:0]] || (w_tag_recent && (w_rd_nxt == r_wr_ptr));
    assign w_frame_end_empty = i_last_data && w_empty && !w_push;

    // Bypass the array when the entry about to be presented is being written this edge.
    assign w_src  = (w_push && (w_rd_nxt == r_wr_ptr)) ? {i_r, i_y_hat} : r_mem[w_rd_nxt[AW-1:0]];
    assign w_base = 9'(w_idx_nxt) * 9'd40;
    assign w_word = w_src[w_base +: 40];

    // Next-state and next word-index selection.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_SEND: begin
                if (w_pop) begin
                    w_idx_nxt = 4'd0;
                    if (w_pop_last) begin
                        w_state_nxt = ST_DONE;
                    end else if (w_avail) begin
                        w_state_nxt = ST_SEND;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_accept) begin
                    w_idx_nxt = r_idx + 4'd1;
                end else begin
                    w_idx_nxt = r_idx;
                end
            end
            ST_IDLE, ST_DONE: begin
                w_idx_nxt = 4'd0;
                if (w_frame_end_empty) begin
                    w_state_nxt = ST_DONE;
                end else if (w_avail) begin
                    w_state_nxt = ST_SEND;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_idx_nxt   = 4'd0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Result storage; payload needs no reset since occupancy is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {i_r, i_y_hat};
        end
    end

    // FSM, pointers, tags and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= 4'd0;
            r_wr_ptr     <= {(AW+1){1'b0}};
            r_rd_ptr     <= {(AW+1){1'b0}};
            r_tag        <= {DEPTH{1'b0}};
            r_data       <= 40'd0;
            r_valid      <= 1'b0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_frame_done <= 1'b0;
            r_res_cnt    <= 4'd0;
            r_ovf        <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            if (w_push) begin
                r_tag[r_wr_ptr[AW-1:0]] <= i_last_data;
            end else if (w_tag_recent) begin
                r_tag[w_wr_prev[AW-1:0]] <= 1'b1;
            end
            r_valid      <= (w_state_nxt == ST_SEND);
            r_data       <= (w_state_nxt == ST_SEND) ? w_word : 40'd0;
            r_sop        <= (w_state_nxt == ST_SEND) && (w_idx_nxt == 4'd0);
            r_eop        <= (w_state_nxt == ST_SEND) && (w_idx_nxt == 4'd11);
            r_frame_done <= (w_state_nxt == ST_DONE);
            if (r_state == ST_DONE) begin
                r_res_cnt <= 4'd0;
            end else if (w_pop && (r_res_cnt != 4'd15)) begin
                r_res_cnt <= r_res_cnt + 4'd1;
            end
            r_ovf <= r_ovf || (i_rd_vld && !w_push);
        end
    end

    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_sop        = r_sop;
    assign o_eop        = r_eop;
    assign o_frame_done = r_frame_done;
    assign o_res_cnt    = r_res_cnt;
    assign o_ovf        = r_ovf;

endmodule

// File: tb/tb_qr_result_serializer.sv
// Scoreboard bench for qr_result_serializer: stimulus pushes expected words and
// frame-done events; a negedge monitor pops and compares them.
module tb_qr_result_serializer;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_rd_vld = 1'b0;
    logic         i_last_data = 1'b0;
    logic [159:0] i_y_hat = 160'd0;
    logic [319:0] i_r = 320'd0;
    logic         i_ready = 1'b1;
    logic [39:0]  o_data;
    logic         o_valid, o_sop, o_eop, o_frame_done, o_ovf;
    logic [3:0]   o_res_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [41:0] sb_q[$];
    logic [4:0]  fd_q[$];
    bit sb_ign = 1'b0;
    bit prev_fd = 1'b0;
    bit prev_eop_acc = 1'b0;

    qr_result_serializer #(.DEPTH(2)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rd_vld(i_rd_vld), .i_last_data(i_last_data),
        .i_y_hat(i_y_hat), .i_r(i_r), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_sop(o_sop), .o_eop(o_eop), .o_frame_done(o_frame_done), .o_res_cnt(o_res_cnt),
        .o_ovf(o_ovf)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    function automatic logic [159:0] mk_y(input logic [39:0] base);
        logic [159:0] y;
        for (int k = 0; k < 4; k++) y[40*k +: 40] = base + 40'(k);
        return y;
    endfunction

    function automatic logic [319:0] mk_r(input logic [39:0] base);
        logic [319:0] r;
        for (int k = 0; k < 8; k++) r[40*k +: 40] = base + 40'(k);
        return r;
    endfunction

    task automatic push_exp(input logic [159:0] y, input logic [319:0] r);
        for (int k = 0; k < 4; k++) sb_q.push_back({(k == 0), 1'b0, y[40*k +: 40]});
        for (int k = 0; k < 8; k++) sb_q.push_back({1'b0, (k == 7), r[40*k +: 40]});
    endtask

    // Issue one result pulse; returns at posedge+1 after the write edge.
    task automatic rd_pulse(input logic [159:0] y, input logic [319:0] r, input bit expect_sent);
        if (expect_sent) push_exp(y, r);
        i_y_hat  = y;
        i_r      = r;
        i_rd_vld = 1'b1;
        cyc(1);
        i_rd_vld = 1'b0;
        i_y_hat  = {5{32'hDEADBEEF}};
        i_r      = {10{32'hBADC0FFE}};
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 600) begin
            cyc(1);
            t++;
        end
        chk(name, 64'(sb_q.size()), 64'd0);
        cyc(3);
    endtask

    task automatic wait_word(input logic [39:0] w, input string name);
        int t;
        t = 0;
        while (!(o_valid && o_data == w) && t < 100) begin
            cyc(1);
            t++;
        end
        chk(name, 64'(o_valid && o_data == w), 64'd1);
    endtask

    // Monitor: compares every accepted word and frame-done pulse against the queues.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            prev_fd = 1'b0;
            prev_eop_acc = 1'b0;
        end else begin
            if (prev_fd) chk("res_cnt_cleared", 64'(o_res_cnt), 64'd0);
            if (o_frame_done) begin
                if (fd_q.size() == 0) begin
                    chk("unexpected_frame_done", 64'd1, 64'd0);
                end else begin
                    logic [4:0] e;
                    e = fd_q.pop_front();
                    chk("fd_res_cnt", 64'(o_res_cnt), 64'(e[3:0]));
                    chk("fd_after_eop", 64'(prev_eop_acc), 64'(e[4]));
                end
            end
            if (o_valid && i_ready && !sb_ign) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_word", 64'(o_data), 64'd0);
                end else begin
                    logic [41:0] e;
                    e = sb_q.pop_front();
                    chk("sb_word", 64'({o_sop, o_eop, o_data}), 64'(e));
                end
            end
            prev_fd = o_frame_done;
            prev_eop_acc = o_valid && i_ready && o_eop;
        end
    end

    initial begin
        cyc(3);
        chk("rst_outputs", 64'({o_valid, o_sop, o_eop, o_frame_done, o_ovf, o_res_cnt, o_data}), 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        cyc(2);

        // single entry, words 1..4 then 0x100..0x107
        rd_pulse(mk_y(40'd1), mk_r(40'h100), 1'b1);
        chk("latency_valid", 64'({o_valid, o_sop}), 64'h3);
        chk("latency_data", 64'(o_data), 64'd1);
        wait_drain("drain_single");
        chk("res_cnt_one", 64'(o_res_cnt), 64'd1);

        // backpressure at word 6
        rd_pulse(mk_y(40'h20), mk_r(40'h100), 1'b1);
        wait_word(40'h102, "reach_word6");
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("stall_hold", 64'({o_valid, o_sop, o_eop, o_data}), {24'd0, 3'b100, 40'h102});
        end
        i_ready = 1'b1;
        wait_drain("drain_bp");
        chk("res_cnt_two", 64'(o_res_cnt), 64'd2);

        // lone end-of-frame with empty FIFO
        fd_q.push_back({1'b0, 4'd2});
        i_last_data = 1'b1;
        cyc(1);
        i_last_data = 1'b0;
        chk("lone_fd_pulse", 64'(o_frame_done), 64'd1);
        cyc(1);
        chk("lone_fd_end", 64'({o_frame_done, o_res_cnt}), 64'd0);

        // ten-entry frame, end of frame one cycle after the tenth result
        for (int j = 0; j < 10; j++) begin
            rd_pulse(mk_y(40'(j * 16)), mk_r(40'(32'h1000 * (j + 1))), 1'b1);
            if (j == 9) begin
                fd_q.push_back({1'b1, 4'd10});
                i_last_data = 1'b1;
                cyc(1);
                i_last_data = 1'b0;
            end else begin
                cyc(19);
            end
        end
        wait_drain("drain_frame");
        chk("frame_fd_seen", 64'(fd_q.size()), 64'd0);
        chk("frame_cnt_zero", 64'(o_res_cnt), 64'd0);

        // overflow with a stalled sink
        i_ready = 1'b0;
        rd_pulse(mk_y(40'h300), mk_r(40'h3100), 1'b1);
        rd_pulse(mk_y(40'h400), mk_r(40'h4100), 1'b1);
        chk("ovf_before", 64'(o_ovf), 64'd0);
        rd_pulse(mk_y(40'h500), mk_r(40'h5100), 1'b0);
        chk("ovf_after", 64'(o_ovf), 64'd1);
        i_ready = 1'b1;
        wait_drain("drain_ovf");

        // reset in the middle of an entry
        sb_ign = 1'b1;
        rd_pulse(mk_y(40'h600), mk_r(40'h500), 1'b0);
        wait_word(40'h501, "reach_word5");
        i_rst_n = 1'b0;
        #1;
        chk("async_rst", 64'({o_valid, o_sop, o_eop, o_frame_done, o_ovf, o_res_cnt, o_data}), 64'd0);
        cyc(2);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        sb_ign = 1'b0;
        cyc(2);
        chk("post_rst_idle", 64'({o_valid, o_ovf}), 64'd0);
        fd_q.push_back({1'b0, 4'd0});
        i_last_data = 1'b1;
        cyc(1);
        i_last_data = 1'b0;
        chk("post_rst_fd", 64'(o_frame_done), 64'd1);
        cyc(2);

        // full FIFO with word 11 accepted on the same edge as a new result
        i_ready = 1'b0;
        rd_pulse(mk_y(40'h700), mk_r(40'h7100), 1'b1);
        rd_pulse(mk_y(40'h800), mk_r(40'h8100), 1'b1);
        i_ready = 1'b1;
        wait_word(40'h7107, "reach_eop_a");
        rd_pulse(mk_y(40'h900), mk_r(40'h9100), 1'b1);
        chk("no_bubble", 64'({o_valid, o_sop, o_data}), {22'd0, 2'b11, 40'h800});
        chk("ovf_stays_0", 64'(o_ovf), 64'd0);
        wait_drain("drain_full");
        chk("ovf_final", 64'(o_ovf), 64'd0);
        chk("res_cnt_three", 64'(o_res_cnt), 64'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
